// File: rtl/sound_cmd_writer.sv
// Main-board sound-command latch writer for the 1942 sound Z80.
// Queues host bytes, presents each until read N times, and paces int_n.
module sound_cmd_writer #(
    parameter int          FIFO_AW       = 2,
    parameter int          READS_PER_CMD = 2,
    parameter logic [15:0] INT_PERIOD    = 16'd1000,
    parameter logic [15:0] INT_WIDTH     = 16'd32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       cmd_in,
    input  logic             cmd_wr,
    output logic             cmd_full,
    output logic [FIFO_AW:0] fifo_level,
    input  logic             snd_latch_cs,
    input  logic             snd_rd_n,
    output logic [7:0]       latch_dout,
    input  logic             int_en,
    output logic             int_n,
    output logic             busy
);

    localparam int               DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]       RPC      = 8'(READS_PER_CMD);
    localparam logic [15:0]      INT_LOW  = INT_PERIOD - INT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_CLEAR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [7:0]         r_latch;
    logic [7:0]         r_rcnt;
    logic               r_rd_n;
    logic               w_rd_evt;
    logic [15:0]        r_icnt;
    logic [15:0]        w_icnt_nxt;
    logic               r_int_n;

    assign w_push     = cmd_wr & ~cmd_full;
    assign w_pop      = (r_state == S_LOAD);
    assign w_empty    = (r_count == '0);
    assign cmd_full   = (r_count == FULL_LVL);
    assign fifo_level = r_count;

    // Falling edge of rd_n while decoded; one event per edge.
    assign w_rd_evt = r_rd_n & ~snd_rd_n & snd_latch_cs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= cmd_in;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_latch <= '0;
            r_rcnt  <= '0;
            r_rd_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_rd_n  <= snd_rd_n;
            if (w_pop) begin
                r_latch <= r_mem[r_rptr];
                r_rcnt  <= '0;
            end else if (r_state == S_PRESENT && w_rd_evt) begin
                r_rcnt <= r_rcnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        latch_dout  = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                latch_dout = r_latch;
                busy       = 1'b1;
                if (w_rd_evt && (r_rcnt + 8'd1 == RPC)) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // int_n is registered from the next count so it lines up with the counter.
    assign w_icnt_nxt = (r_icnt == INT_PERIOD - 16'd1) ? '0 : r_icnt + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_icnt  <= '0;
            r_int_n <= 1'b1;
        end else if (!int_en) begin
            r_icnt  <= '0;
            r_int_n <= 1'b1;
        end else begin
            r_icnt  <= w_icnt_nxt;
            r_int_n <= (w_icnt_nxt < INT_LOW);
        end
    end

    assign int_n = r_int_n;

endmodule

// File: tb/tb_sound_cmd_writer.sv
// Bench for sound_cmd_writer: timestamp model of queue/latch/interrupt
// compared every cycle, plus directed literal checks.
module tb_sound_cmd_writer;

    localparam int P     = 100;
    localparam int W     = 10;
    localparam int DEPTH = 4;
    localparam int RPC   = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] cmd_in = '0;
    logic       cmd_wr = 1'b0;
    logic       cmd_full;
    logic [2:0] fifo_level;
    logic       snd_latch_cs = 1'b0;
    logic       snd_rd_n = 1'b1;
    logic [7:0] latch_dout;
    logic       int_en = 1'b1;
    logic       int_n;
    logic       busy;

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;

    sound_cmd_writer #(
        .FIFO_AW(2),
        .READS_PER_CMD(RPC),
        .INT_PERIOD(16'd100),
        .INT_WIDTH(16'd10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_in(cmd_in),
        .cmd_wr(cmd_wr),
        .cmd_full(cmd_full),
        .fifo_level(fifo_level),
        .snd_latch_cs(snd_latch_cs),
        .snd_rd_n(snd_rd_n),
        .latch_dout(latch_dout),
        .int_en(int_en),
        .int_n(int_n),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Model: each command starts at max(write+3, previous retire+4).
    typedef struct {
        logic [7:0] d;
        int         wr;
    } ent_t;

    ent_t       m_q[$];
    logic       m_cur_v = 1'b0;
    logic [7:0] m_cur_d = '0;
    int         m_reads = 0;
    int         m_last_ret = -100;
    logic       m_prev_rd = 1'b1;
    int         m_origin = 0;
    int         m_t;
    int         m_st;
    int         m_lvl;
    logic       m_evt;

    always @(negedge clk) begin
        m_t = cyc;
        if (!reset_n) begin
            chk("m_rst_latch", latch_dout, 0);
            chk("m_rst_busy", busy, 0);
            chk("m_rst_full", cmd_full, 0);
            chk("m_rst_level", fifo_level, 0);
            chk("m_rst_int_n", int_n, 1);
            m_q.delete();
            m_cur_v    = 1'b0;
            m_last_ret = m_t - 100;
            m_prev_rd  = 1'b1;
            m_origin   = m_t + 1;
        end else begin
            if (!m_cur_v && m_q.size() > 0) begin
                m_st = m_q[0].wr + 3;
                if (m_last_ret + 4 > m_st) m_st = m_last_ret + 4;
                if (m_st <= m_t) begin
                    m_cur_v = 1'b1;
                    m_cur_d = m_q[0].d;
                    m_reads = 0;
                    void'(m_q.pop_front());
                end
            end
            m_lvl = m_q.size();
            chk("m_latch", latch_dout, m_cur_v ? m_cur_d : 8'h00);
            chk("m_busy", busy, m_cur_v);
            chk("m_level", fifo_level, m_lvl);
            chk("m_full", cmd_full, m_lvl == DEPTH);
            chk("m_int_n", int_n, ((m_t - m_origin) % P >= P - W) ? 0 : 1);
            m_evt = m_prev_rd && !snd_rd_n && snd_latch_cs;
            if (m_cur_v && m_evt) begin
                m_reads++;
                if (m_reads == RPC) begin
                    m_cur_v    = 1'b0;
                    m_last_ret = m_t;
                end
            end
            if (cmd_wr && m_lvl < DEPTH) m_q.push_back('{cmd_in, m_t});
            m_prev_rd = snd_rd_n;
            if (!int_en) m_origin = m_t + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic write_byte(input logic [7:0] v);
        cmd_in = v;
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        while (!busy && k < 20) begin
            tick();
            k++;
        end
        chk(name, busy, 1);
    endtask

    task automatic rd_pulse(input logic cs, input int low);
        snd_latch_cs = cs;
        snd_rd_n = 1'b0;
        repeat (low) tick();
        snd_rd_n = 1'b1;
        tick();
    endtask

    // Retire cur with the second read, then time the zero gap to nxt.
    task automatic retire_next(input logic [7:0] cur, input logic [7:0] nxt);
        int zeros = 0;
        rd_pulse(1'b1, 1);
        snd_rd_n = 1'b0;
        chk("ord_cur", latch_dout, cur);
        tick();
        snd_rd_n = 1'b1;
        while (latch_dout == 8'h00 && zeros < 20) begin
            zeros++;
            tick();
        end
        chk("ord_next", latch_dout, nxt);
        chk("ord_gap", zeros >= 3, 1);
    endtask

    int base;
    int k;

    initial begin
        repeat (3) tick();
        chk("rst_latch", latch_dout, 8'h00);
        chk("rst_int_n", int_n, 1);
        chk("rst_level", fifo_level, 0);
        reset_n = 1'b1;
        base = cyc;

        wait_to(base + 89);
        chk("int_89", int_n, 1);
        tick();
        chk("int_90", int_n, 0);
        wait_to(base + 99);
        chk("int_99", int_n, 0);
        tick();
        chk("int_100", int_n, 1);
        wait_to(base + 195);
        chk("int_195", int_n, 0);
        int_en = 1'b0;
        tick();
        chk("int_dis_196", int_n, 1);
        wait_to(base + 200);
        int_en = 1'b1;
        wait_to(base + 289);
        chk("int_289", int_n, 1);
        tick();
        chk("int_290", int_n, 0);

        write_byte(8'h12);
        tick();
        chk("lat_n2", latch_dout, 8'h00);
        tick();
        chk("lat_n3", latch_dout, 8'h12);
        chk("lat_busy", busy, 1);
        rd_pulse(1'b1, 1);
        chk("one_read", latch_dout, 8'h12);
        snd_rd_n = 1'b0;
        snd_latch_cs = 1'b1;
        chk("retiring_read", latch_dout, 8'h12);
        tick();
        snd_rd_n = 1'b1;
        chk("clear_latch", latch_dout, 8'h00);
        chk("clear_busy", busy, 0);

        write_byte(8'h34);
        wait_busy("q_present");
        snd_latch_cs = 1'b1;
        snd_rd_n = 1'b0;
        repeat (20) tick();
        snd_rd_n = 1'b1;
        tick();
        chk("long_low", latch_dout, 8'h34);
        repeat (3) rd_pulse(1'b0, 1);
        chk("cs_low", latch_dout, 8'h34);
        snd_latch_cs = 1'b1;
        snd_rd_n = 1'b0;
        tick();
        snd_rd_n = 1'b1;
        chk("qual_retire", latch_dout, 8'h00);
        repeat (4) tick();
        repeat (2) rd_pulse(1'b1, 1);
        write_byte(8'h56);
        wait_busy("idle_present");
        rd_pulse(1'b1, 1);
        chk("idle_reads_ignored", latch_dout, 8'h56);
        rd_pulse(1'b1, 1);
        chk("idle_retire", latch_dout, 8'h00);
        snd_latch_cs = 1'b0;

        repeat (4) tick();
        write_byte(8'h01);
        wait_busy("f_present");
        chk("f_first", latch_dout, 8'h01);
        for (int v = 2; v <= 5; v++) write_byte(8'(v));
        chk("f_full", cmd_full, 1);
        chk("f_level4", fifo_level, 4);
        write_byte(8'h06);
        chk("f_drop_level", fifo_level, 4);
        for (int v = 1; v <= 4; v++) retire_next(8'(v), 8'(v + 1));
        rd_pulse(1'b1, 1);
        rd_pulse(1'b1, 1);
        repeat (10) tick();
        chk("f_end_latch", latch_dout, 8'h00);
        chk("f_end_level", fifo_level, 0);
        snd_latch_cs = 1'b0;

        write_byte(8'hAA);
        wait_busy("pp_present");
        write_byte(8'hBB);
        chk("pp_lvl1", fifo_level, 1);
        rd_pulse(1'b1, 1);
        snd_rd_n = 1'b0;
        tick();
        snd_rd_n = 1'b1;
        tick();
        tick();
        chk("pp_pre", fifo_level, 1);
        cmd_in = 8'hCC;
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
        chk("pp_level", fifo_level, 1);
        chk("pp_b", latch_dout, 8'hBB);
        rd_pulse(1'b1, 1);
        rd_pulse(1'b1, 1);
        wait_busy("pp_c_present");
        chk("pp_c", latch_dout, 8'hCC);
        rd_pulse(1'b1, 1);
        rd_pulse(1'b1, 1);
        chk("pp_done", latch_dout, 8'h00);
        snd_latch_cs = 1'b0;

        write_byte(8'h12);
        wait_busy("r_present");
        write_byte(8'h77);
        write_byte(8'h78);
        chk("r_lvl2", fifo_level, 2);
        k = 0;
        while (int_n && k < 150) begin
            tick();
            k++;
        end
        chk("r_int_low", int_n, 0);
        reset_n = 1'b0;
        #1;
        chk("r_latch", latch_dout, 8'h00);
        chk("r_int_n", int_n, 1);
        chk("r_level", fifo_level, 0);
        chk("r_busy", busy, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        chk("r_after_latch", latch_dout, 8'h00);
        chk("r_after_busy", busy, 0);
        chk("r_after_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
